// File: rtl/airi5c_ahb_slave_mux_pkg.sv
// Shared HASTI (AHB-lite) widths, encodings and the interconnect FSM state type.
package airi5c_ahb_slave_mux_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_FWD  = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  // Index width that stays legal for a single-slave configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/airi5c_ahb_slave_mux_addr_decoder.sv
// Address-window decoder: lowest matching slave index wins; one-hot select gated by en.
module airi5c_addr_decoder
  import airi5c_ahb_slave_mux_pkg::*;
#(
  parameter int                      S_COUNT      = 8,
  parameter logic [S_COUNT*32-1:0]   S_BASE_ADDR  = {32'hC0000700, 32'hC0000600, 32'hC0000500, 32'hC0000400,
                                                     32'hC0000300, 32'hC0000200, 32'hC0000100, 32'h80000000},
  parameter logic [S_COUNT*32-1:0]   S_ADDR_WIDTH = {32'd8, 32'd8, 32'd8, 32'd8,
                                                     32'd8, 32'd8, 32'd8, 32'd28},
  localparam int                     IDX_W        = idx_width(S_COUNT)
) (
  input  logic [HASTI_ADDR_WIDTH-1:0] addr,
  input  logic                        en,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx,
  output logic [S_COUNT-1:0]          sel
);

  logic [S_COUNT-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_match
      // A window width of 32 shifts everything out, so that slave matches all addresses.
      assign match[gi] = ((addr >> S_ADDR_WIDTH[gi*32 +: 32]) ==
                          (S_BASE_ADDR[gi*32 +: 32] >> S_ADDR_WIDTH[gi*32 +: 32]));
    end
  endgenerate

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    sel = '0;
    if (en && hit) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/airi5c_ahb_slave_mux.sv
// HASTI interconnect: address decode, registered data-phase response mux,
// default ERROR slave for unmapped addresses and stalled-slave timeout abort.
module airi5c_ahb_slave_mux
  import airi5c_ahb_slave_mux_pkg::*;
#(
  parameter int                    S_COUNT        = 8,
  parameter logic [S_COUNT*32-1:0] S_BASE_ADDR    = {32'hC0000700, 32'hC0000600, 32'hC0000500, 32'hC0000400,
                                                     32'hC0000300, 32'hC0000200, 32'hC0000100, 32'h80000000},
  parameter logic [S_COUNT*32-1:0] S_ADDR_WIDTH   = {32'd8, 32'd8, 32'd8, 32'd8,
                                                     32'd8, 32'd8, 32'd8, 32'd28},
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [31:0]           DEFAULT_RDATA  = 32'hDEADBEEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [HASTI_ADDR_WIDTH-1:0]           m_haddr,
  input  logic [HASTI_TRANS_WIDTH-1:0]          m_htrans,
  output logic                                  m_hready,
  output logic [HASTI_RESP_WIDTH-1:0]           m_hresp,
  output logic [HASTI_BUS_WIDTH-1:0]            m_hrdata,
  output logic [S_COUNT-1:0]                    s_hsel,
  input  logic [S_COUNT-1:0]                    s_hready,
  input  logic [S_COUNT*HASTI_RESP_WIDTH-1:0]   s_hresp,
  input  logic [S_COUNT*HASTI_BUS_WIDTH-1:0]    s_hrdata,
  output logic                                  timeout_o,
  output logic [HASTI_ADDR_WIDTH-1:0]           err_addr_o
);

  localparam int IDX_W  = idx_width(S_COUNT);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t                        state_reg, state_next;
  logic                          dp_valid_reg;
  logic [IDX_W-1:0]              dp_sel_reg;
  logic [HASTI_ADDR_WIDTH-1:0]   dp_addr_reg;
  logic [HASTI_ADDR_WIDTH-1:0]   err_addr_reg;
  logic [CNT_W-1:0]              cnt_reg;
  logic                          abort_reg;

  logic                          active, hit, miss, stall, timeout_hit;
  logic [IDX_W-1:0]              idx;
  logic                          unused_htrans;

  assign active        = m_htrans[1];
  assign unused_htrans = m_htrans[0];
  assign miss          = active & ~hit;

  airi5c_addr_decoder #(
    .S_COUNT      (S_COUNT),
    .S_BASE_ADDR  (S_BASE_ADDR),
    .S_ADDR_WIDTH (S_ADDR_WIDTH)
  ) u_decoder (
    .addr (m_haddr),
    .en   (active & ~rst_i),
    .hit  (hit),
    .idx  (idx),
    .sel  (s_hsel)
  );

  assign stall       = dp_valid_reg & ~s_hready[dp_sel_reg];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_reg == ST_FWD) && stall &&
                       (cnt_reg == CNT_W'(LAST));

  always_comb begin
    m_hready   = 1'b1;
    m_hresp    = HASTI_RESP_OKAY;
    m_hrdata   = '0;
    state_next = ST_FWD;
    case (state_reg)
      ST_FWD: begin
        if (dp_valid_reg) begin
          m_hready = s_hready[dp_sel_reg];
          m_hresp  = s_hresp[dp_sel_reg*HASTI_RESP_WIDTH +: HASTI_RESP_WIDTH];
          m_hrdata = s_hrdata[dp_sel_reg*HASTI_BUS_WIDTH +: HASTI_BUS_WIDTH];
        end
        if ((m_hready && miss) || timeout_hit) state_next = ST_ERR1;
      end
      ST_ERR1: begin
        m_hready   = 1'b0;
        m_hresp    = HASTI_RESP_ERROR;
        m_hrdata   = DEFAULT_RDATA;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        m_hresp  = HASTI_RESP_ERROR;
        m_hrdata = DEFAULT_RDATA;
        if (miss) state_next = ST_ERR1;
      end
      default: state_next = ST_FWD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_FWD;
      dp_valid_reg <= 1'b0;
      dp_sel_reg   <= '0;
      dp_addr_reg  <= '0;
      err_addr_reg <= '0;
      cnt_reg      <= '0;
      abort_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (m_hready) begin
        dp_valid_reg <= active & hit;
        dp_sel_reg   <= idx;
        dp_addr_reg  <= m_haddr;
      end else if (timeout_hit) begin
        // The stalled slave is abandoned; its late HREADYOUT must not be forwarded.
        dp_valid_reg <= 1'b0;
      end
      if (m_hready && miss) err_addr_reg <= m_haddr;
      else if (timeout_hit) err_addr_reg <= dp_addr_reg;
      if (timeout_hit) abort_reg <= 1'b1;
      else if ((state_reg == ST_ERR2) || (m_hready && miss)) abort_reg <= 1'b0;
      if (m_hready || (state_reg != ST_FWD) || timeout_hit) cnt_reg <= '0;
      else if ((TIMEOUT_CYCLES != 0) && stall && (cnt_reg != CNT_W'(TIMEOUT_CYCLES)))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout_o  = (state_reg == ST_ERR2) && abort_reg;
  assign err_addr_o = err_addr_reg;

endmodule

// File: tb/tb_airi5c_ahb_slave_mux.sv
// Directed bench for the HASTI slave mux: decode, stalls, default slave, timeout, reset.
module tb_airi5c_ahb_slave_mux;
  import airi5c_ahb_slave_mux_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  m_haddr;
  logic [1:0]   m_htrans;
  logic         m_hready;
  logic [0:0]   m_hresp;
  logic [31:0]  m_hrdata;
  logic [7:0]   s_hsel;
  logic [7:0]   s_hready;
  logic [7:0]   s_hresp;
  logic [255:0] s_hrdata;
  logic         timeout_o;
  logic [31:0]  err_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  airi5c_ahb_slave_mux #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_haddr    (m_haddr),
    .m_htrans   (m_htrans),
    .m_hready   (m_hready),
    .m_hresp    (m_hresp),
    .m_hrdata   (m_hrdata),
    .s_hsel     (s_hsel),
    .s_hready   (s_hready),
    .s_hresp    (s_hresp),
    .s_hrdata   (s_hrdata),
    .timeout_o  (timeout_o),
    .err_addr_o (err_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [1:0] t);
    m_haddr  = a;
    m_htrans = t;
  endtask

  task automatic resp(input string tag, input logic rdy, input logic r, input logic [31:0] d);
    #2;
    $display("t=%0t %s: hready=%b hresp=%b hrdata=%h hsel=%b timeout=%b err_addr=%h",
             $time, tag, m_hready, m_hresp, m_hrdata, s_hsel, timeout_o, err_addr_o);
    chk({tag, ".hready"}, {31'd0, m_hready}, {31'd0, rdy});
    chk({tag, ".hresp"},  {31'd0, m_hresp},  {31'd0, r});
    chk({tag, ".hrdata"}, m_hrdata, d);
  endtask

  initial begin
    rst_i    = 1'b1;
    s_hready = 8'hFF;
    s_hresp  = '0;
    for (int i = 0; i < 8; i++) s_hrdata[i*32 +: 32] = 32'hA0000000 + 32'(i);
    s_hrdata[2*32 +: 32] = 32'h12345678;
    bus(32'hC0000204, HASTI_TRANS_NONSEQ);
    #1;
    cyc();
    #2;
    chk("rst_hsel_forced", {24'd0, s_hsel}, 32'h0);
    cyc();
    rst_i = 1'b0;
    bus(32'h0, HASTI_TRANS_IDLE);
    resp("reset", 1'b1, 1'b0, 32'h0);
    chk("reset.timeout", {31'd0, timeout_o}, 32'h0);
    chk("reset.err_addr", err_addr_o, 32'h0);

    // Mapped read from slave 2
    bus(32'hC0000204, HASTI_TRANS_NONSEQ);
    #2;
    chk("rd2.hsel", {24'd0, s_hsel}, 32'h04);
    cyc();
    bus(32'h0, HASTI_TRANS_IDLE);
    resp("rd2.data", 1'b1, 1'b0, 32'h12345678);
    cyc();

    // Unmapped access: two-cycle ERROR
    bus(32'hD0000000, HASTI_TRANS_NONSEQ);
    #2;
    chk("miss.hsel", {24'd0, s_hsel}, 32'h0);
    cyc();
    bus(32'h0, HASTI_TRANS_IDLE);
    resp("miss.err1", 1'b0, 1'b1, 32'hDEADBEEF);
    cyc();
    resp("miss.err2", 1'b1, 1'b1, 32'hDEADBEEF);
    chk("miss.err_addr", err_addr_o, 32'hD0000000);
    chk("miss.timeout", {31'd0, timeout_o}, 32'h0);
    cyc();
    resp("miss.after", 1'b1, 1'b0, 32'h0);

    // Slave 1 stalls three cycles; next address (slave 3) held until release
    bus(32'hC0000100, HASTI_TRANS_NONSEQ);
    cyc();
    s_hready[1] = 1'b0;
    s_hrdata[1*32 +: 32] = 32'hCAFE0001;
    bus(32'hC0000300, HASTI_TRANS_NONSEQ);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall.hready", {31'd0, m_hready}, 32'h0);
      chk("stall.hsel", {24'd0, s_hsel}, 32'h08);
      cyc();
    end
    s_hready[1] = 1'b1;
    resp("stall.release", 1'b1, 1'b0, 32'hCAFE0001);
    cyc();
    bus(32'h0, HASTI_TRANS_IDLE);
    s_hrdata[3*32 +: 32] = 32'h33333333;
    resp("stall.next_s3", 1'b1, 1'b0, 32'h33333333);
    cyc();

    // Timeout: slave 5 stuck low
    bus(32'hC0000500, HASTI_TRANS_NONSEQ);
    s_hready[5] = 1'b0;
    cyc();
    bus(32'h0, HASTI_TRANS_IDLE);
    for (int k = 0; k < 4; k++) begin
      resp("to.stall", 1'b0, 1'b0, 32'hA0000005);
      chk("to.stall_timeout", {31'd0, timeout_o}, 32'h0);
      cyc();
    end
    resp("to.err1", 1'b0, 1'b1, 32'hDEADBEEF);
    chk("to.err1_timeout", {31'd0, timeout_o}, 32'h0);
    cyc();
    resp("to.err2", 1'b1, 1'b1, 32'hDEADBEEF);
    chk("to.err2_timeout", {31'd0, timeout_o}, 32'h1);
    chk("to.err_addr", err_addr_o, 32'hC0000500);
    cyc();
    resp("to.after", 1'b1, 1'b0, 32'h0);
    chk("to.after_timeout", {31'd0, timeout_o}, 32'h0);
    s_hready[5] = 1'b1;
    cyc();
    resp("to.ignored", 1'b1, 1'b0, 32'h0);

    // Back-to-back misses
    bus(32'h00000000, HASTI_TRANS_NONSEQ);
    cyc();
    bus(32'h10000000, HASTI_TRANS_NONSEQ);
    resp("b2b.err1a", 1'b0, 1'b1, 32'hDEADBEEF);
    cyc();
    resp("b2b.err2a", 1'b1, 1'b1, 32'hDEADBEEF);
    chk("b2b.err_addr_a", err_addr_o, 32'h00000000);
    cyc();
    bus(32'h10000000, HASTI_TRANS_IDLE);
    resp("b2b.err1b", 1'b0, 1'b1, 32'hDEADBEEF);
    cyc();
    resp("b2b.err2b", 1'b1, 1'b1, 32'hDEADBEEF);
    chk("b2b.err_addr_b", err_addr_o, 32'h10000000);
    chk("idle.hsel", {24'd0, s_hsel}, 32'h0);
    cyc();
    resp("idle.noerr", 1'b1, 1'b0, 32'h0);

    // Reset during ERR1
    bus(32'hD0000000, HASTI_TRANS_NONSEQ);
    cyc();
    bus(32'h0, HASTI_TRANS_IDLE);
    resp("rst_err1.pre", 1'b0, 1'b1, 32'hDEADBEEF);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    resp("rst_err1.post", 1'b1, 1'b0, 32'h0);
    chk("rst_err1.timeout", {31'd0, timeout_o}, 32'h0);
    chk("rst_err1.err_addr", err_addr_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
